reset_sequencer: RTL

Staged reset release controller driven by a synchronized, stretched system reset. It holds all downstream reset domains in reset until an asynchronous lock/ready indication (e.g. PLL lock) has been stably high for a programmable number of cycles. It then releases the domains one at a time with a fixed gap between them. Loss of lock or a soft-reset request re-asserts every domain and restarts the sequence.

---
 rtl/reset_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reset_sequencer: staged reset release gated by a filtered, synced lock.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reset_sequencer #(
  parameter int STAGES      = 3,
  parameter int GAP         = 3,
  parameter int LOCK_FILTER = 4
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              lock_in,
  input  logic              soft_reset_in,
  output logic [STAGES-1:0] reset_out,
  output logic              done,
  output logic [7:0]        loss_count
);

  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            state;
  logic              sync_meta;
  logic              lock_s;
  logic [FW-1:0]     filter_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [STAGES-1:0] next_out;

  // Shifting in a zero from the bottom releases the lowest still-held stage.
  assign next_out = reset_out << 1;

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      sync_meta  <= 1'b0;
      lock_s     <= 1'b0;
      filter_cnt <= '0;
      gap_cnt    <= '0;
      state      <= WAIT_LOCK;
      reset_out  <= '1;
      done       <= 1'b0;
      loss_count <= 8'd0;
    end else begin
      sync_meta <= lock_in;
      lock_s    <= sync_meta;
      case (state)
        WAIT_LOCK: begin
          if (soft_reset_in || !lock_s) begin
            filter_cnt <= '0;
          end else if (filter_cnt == FW'(LOCK_FILTER - 1)) begin
            filter_cnt   <= '0;
            reset_out[0] <= 1'b0;
            gap_cnt      <= GW'(GAP);
            if (STAGES == 1) begin
              done  <= 1'b1;
              state <= RUN;
            end else begin
              state <= RELEASE;
            end
          end else begin
            filter_cnt <= filter_cnt + 1'b1;
          end
        end
        RELEASE, RUN: begin
          if (!lock_s || soft_reset_in) begin
            reset_out  <= '1;
            done       <= 1'b0;
            filter_cnt <= '0;
            state      <= WAIT_LOCK;
            if (!lock_s && loss_count != 8'hFF)
              loss_count <= loss_count + 1'b1;
          end else if (state == RELEASE) begin
            if (gap_cnt == '0) begin
              reset_out <= next_out;
              gap_cnt   <= GW'(GAP);
              if (next_out == '0) begin
                done  <= 1'b1;
                state <= RUN;
              end
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule
`default_nettype wire
